// File: rtl/train_pkg.sv
// Shared state encoding, fixed-point word type and default sizes for the
// training scheduler.
package train_pkg;

    localparam int BITS_DEF = 16;
    localparam int NX_DEF   = 6;

    typedef logic [BITS_DEF-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        TR_ISS,
        TR_WAIT,
        VL_ISS,
        VL_WAIT,
        EP_END,
        FIN
    } state_t;

endpackage

// File: rtl/sample_buf.sv
// Sample storage: one entry per sample holding {target, features}.
// Synchronous write, combinational read.
module sample_buf #(
    parameter int DEPTH = 8,
    parameter int W     = 112,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/train_sched.sv
// Training-run scheduler: buffers samples, then alternates train and validate
// passes over them against an external network until clean or out of epochs.
module train_sched
    import train_pkg::*;
#(
    parameter int NX    = NX_DEF,
    parameter int BITS  = BITS_DEF,
    parameter int DEPTH = 8,
    parameter int EW    = 8,
    parameter int TMO   = 2048
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [NX*BITS-1:0]         ld_x,
    input  logic [BITS-1:0]            ld_y,
    input  logic                       clr,
    input  logic                       start,
    input  logic [EW-1:0]              max_ep,
    input  logic [BITS-1:0]            lr_in,
    output logic                       net_tr,
    output logic                       net_vl,
    output logic [NX*BITS-1:0]         net_x,
    output logic [BITS-1:0]            net_y,
    output logic [BITS-1:0]            net_lr,
    input  logic                       net_done,
    input  logic                       net_err,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout,
    output logic [EW-1:0]              epoch,
    output logic [$clog2(DEPTH+1)-1:0] errs
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = $clog2(TMO+1);
    localparam int SW = (NX+1)*BITS;

    state_t        state, state_n;
    logic [CW-1:0] count, idx, count_eff;
    logic [EW-1:0] max_ep_q, epoch_inc;
    logic [TW-1:0] tmr;
    logic [SW-1:0] rd_data;
    logic          load_fire, clr_idle, start_ok, last, tmo_hit, in_sample;
    logic          idx_clr, idx_inc, errs_clr, err_inc, ep_inc, to_set;

    sample_buf #(
        .DEPTH (DEPTH),
        .W     (SW),
        .AW    (AW)
    ) u_buf (
        .clk   (clk),
        .we    (load_fire),
        .waddr (count[AW-1:0]),
        .wdata ({ld_y, ld_x}),
        .raddr (idx[AW-1:0]),
        .rdata (rd_data)
    );

    // A load in the same cycle as start is counted so the run includes it.
    assign clr_idle  = clr && (state == IDLE);
    assign load_fire = ld_valid && ld_ready && !clr;
    assign count_eff = clr_idle ? '0 : count + CW'(load_fire);
    assign start_ok  = start && (state == IDLE) && (max_ep != '0) && (count_eff != '0);
    assign last      = (idx == count - CW'(1));
    assign tmo_hit   = (tmr == TW'(TMO - 1));
    assign epoch_inc = (epoch == '1) ? epoch : epoch + EW'(1);

    assign in_sample = (state == TR_ISS) || (state == TR_WAIT) ||
                       (state == VL_ISS) || (state == VL_WAIT);
    assign net_x     = in_sample ? rd_data[NX*BITS-1:0] : '0;
    assign net_y     = in_sample ? rd_data[SW-1 -: BITS] : '0;

    always_comb begin
        state_n  = state;
        ld_ready = 1'b0;
        net_tr   = 1'b0;
        net_vl   = 1'b0;
        done     = 1'b0;
        busy     = (state != IDLE);
        idx_clr  = 1'b0;
        idx_inc  = 1'b0;
        errs_clr = 1'b0;
        err_inc  = 1'b0;
        ep_inc   = 1'b0;
        to_set   = 1'b0;
        case (state)
            IDLE: begin
                ld_ready = (count < CW'(DEPTH));
                if (start_ok) begin
                    idx_clr  = 1'b1;
                    errs_clr = 1'b1;
                    state_n  = TR_ISS;
                end
            end
            TR_ISS: begin
                net_tr  = 1'b1;
                state_n = TR_WAIT;
            end
            TR_WAIT: begin
                if (net_done) begin
                    if (last) begin
                        idx_clr  = 1'b1;
                        errs_clr = 1'b1;
                        state_n  = VL_ISS;
                    end else begin
                        idx_inc = 1'b1;
                        state_n = TR_ISS;
                    end
                end else if (tmo_hit) begin
                    to_set  = 1'b1;
                    state_n = FIN;
                end
            end
            VL_ISS: begin
                net_vl  = 1'b1;
                state_n = VL_WAIT;
            end
            VL_WAIT: begin
                if (net_done) begin
                    err_inc = net_err;
                    if (last) begin
                        state_n = EP_END;
                    end else begin
                        idx_inc = 1'b1;
                        state_n = VL_ISS;
                    end
                end else if (tmo_hit) begin
                    to_set  = 1'b1;
                    state_n = FIN;
                end
            end
            EP_END: begin
                ep_inc = 1'b1;
                if ((errs == '0) || (epoch_inc == max_ep_q)) begin
                    state_n = FIN;
                end else begin
                    idx_clr = 1'b1;
                    state_n = TR_ISS;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            idx      <= '0;
            epoch    <= '0;
            errs     <= '0;
            timeout  <= 1'b0;
            net_lr   <= '0;
            max_ep_q <= '0;
            tmr      <= '0;
        end else begin
            state <= state_n;
            if (clr_idle) begin
                count <= '0;
            end else if (load_fire) begin
                count <= count + CW'(1);
            end
            if (start_ok) begin
                net_lr   <= lr_in;
                max_ep_q <= max_ep;
            end
            if (idx_clr) begin
                idx <= '0;
            end else if (idx_inc) begin
                idx <= idx + CW'(1);
            end
            if (errs_clr) begin
                errs <= '0;
            end else if (err_inc) begin
                errs <= errs + CW'(1);
            end
            if (start_ok) begin
                epoch <= '0;
            end else if (ep_inc) begin
                epoch <= epoch_inc;
            end
            if (start_ok) begin
                timeout <= 1'b0;
            end else if (to_set) begin
                timeout <= 1'b1;
            end
            // Wait states are only entered from their issue state.
            if ((state == TR_ISS) || (state == VL_ISS)) begin
                tmr <= '0;
            end else if ((state == TR_WAIT) || (state == VL_WAIT)) begin
                tmr <= tmr + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_train_sched.sv
// Directed bench for train_sched with a transaction-level model of the
// expected pulse sequence, per-cycle checks and a fixed-latency responder.
module tb_train_sched;
    import train_pkg::*;

    localparam int NX    = 6;
    localparam int BITS  = 16;
    localparam int DEPTH = 8;
    localparam int EW    = 8;
    localparam int TMO   = 2048;
    localparam int LAT   = 5;
    localparam int CW    = $clog2(DEPTH+1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ld_valid = 1'b0, clr = 1'b0, start = 1'b0;
    logic              net_done = 1'b0, net_err = 1'b0;
    logic [NX*BITS-1:0] ld_x = '0;
    logic [BITS-1:0]   ld_y = '0, lr_in = '0;
    logic [EW-1:0]     max_ep = '0;
    logic              ld_ready, net_tr, net_vl, busy, done, timeout;
    logic [NX*BITS-1:0] net_x;
    logic [BITS-1:0]   net_y, net_lr;
    logic [EW-1:0]     epoch;
    logic [CW-1:0]     errs;

    always #5 clk = ~clk;

    train_sched #(
        .NX    (NX),
        .BITS  (BITS),
        .DEPTH (DEPTH),
        .EW    (EW),
        .TMO   (TMO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_x     (ld_x),
        .ld_y     (ld_y),
        .clr      (clr),
        .start    (start),
        .max_ep   (max_ep),
        .lr_in    (lr_in),
        .net_tr   (net_tr),
        .net_vl   (net_vl),
        .net_x    (net_x),
        .net_y    (net_y),
        .net_lr   (net_lr),
        .net_done (net_done),
        .net_err  (net_err),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout),
        .epoch    (epoch),
        .errs     (errs)
    );

    int errors = 0;
    int checks = 0;

    // Model: buffered samples, run status and the expected pulse sequence
    // (entry = kind*256 + sample index, kind 0 = train, 1 = validate).
    logic [NX*BITS-1:0] m_xs [DEPTH];
    logic [BITS-1:0]    m_ys [DEPTH];
    int                 m_cnt = 0;
    bit                 m_busy = 1'b0;
    bit                 done_seen = 1'b0;
    logic [BITS-1:0]    m_lr = '0;
    int                 m_exp_epoch = 0, m_exp_errs = 0;
    bit                 m_tmo_exp = 1'b0;
    logic [DEPTH-1:0]   errmask = '0;
    int                 exp_q [$];
    int                 tr_cnt = 0, vl_cnt = 0, cyc = 0, tr_cyc = 0;
    bit                 resp_on = 1'b1;
    int                 resp_cnt = -1;
    bit                 resp_err = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void build_plan(input int n, input int mep);
        int pass_errs = 0;
        exp_q.delete();
        for (int i = 0; i < n; i++) if (errmask[i]) pass_errs++;
        if (m_tmo_exp) begin
            exp_q.push_back(0);
            m_exp_epoch = 0;
            m_exp_errs  = 0;
            return;
        end
        for (int e = 1; e <= mep; e++) begin
            for (int i = 0; i < n; i++) exp_q.push_back(i);
            for (int i = 0; i < n; i++) exp_q.push_back(256 + i);
            m_exp_epoch = e;
            m_exp_errs  = pass_errs;
            if (pass_errs == 0) break;
        end
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_cnt = 0;
            m_busy = 1'b0;
            done_seen = 1'b0;
            exp_q.delete();
        end else if (done_seen) begin
            m_busy = 1'b0;
            done_seen = 1'b0;
        end else if (!m_busy) begin
            if (clr) begin
                m_cnt = 0;
            end else if (ld_valid && m_cnt < DEPTH) begin
                m_xs[m_cnt] = ld_x;
                m_ys[m_cnt] = ld_y;
                m_cnt++;
            end
            if (start && max_ep != 0 && m_cnt > 0) begin
                m_busy = 1'b1;
                m_lr = lr_in;
                build_plan(m_cnt, int'(max_ep));
            end
        end
    end

    always @(negedge clk) begin : compare
        int head;
        if (!rst_n) begin
            net_done = 1'b0;
            net_err  = 1'b0;
            resp_cnt = -1;
        end else begin
            if (net_done) begin
                net_done = 1'b0;
                net_err  = 1'b0;
            end
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    net_done = 1'b1;
                    net_err  = resp_err;
                    resp_cnt = -1;
                end
            end
            chk("tr_vl_excl", net_tr & net_vl, 0);
            chk("busy", busy, m_busy);
            chk("ld_ready", ld_ready, !m_busy && m_cnt < DEPTH);
            if (net_tr || net_vl) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pulse_unexpected: got tr=%0d vl=%0d expected none", net_tr, net_vl);
                end else begin
                    head = exp_q.pop_front();
                    chk("pulse_kind", net_vl, head >= 256);
                    chk("net_x", net_x, m_xs[head % 256]);
                    chk("net_y", net_y, m_ys[head % 256]);
                    chk("net_lr", net_lr, m_lr);
                    if (resp_on) begin
                        resp_cnt = LAT;
                        resp_err = net_vl && errmask[head % 256];
                    end
                end
                if (net_tr) begin
                    tr_cnt++;
                    tr_cyc = cyc;
                end else begin
                    vl_cnt++;
                end
            end
            if (done) begin
                chk("done_epoch", epoch, m_exp_epoch);
                chk("done_errs", errs, m_exp_errs);
                chk("done_timeout", timeout, m_tmo_exp);
                if (!m_tmo_exp) chk("done_all_pulses", exp_q.size(), 0);
                exp_q.delete();
                done_seen = 1'b1;
            end
        end
    end

    task automatic load_sample(input int i);
        ld_valid = 1'b1;
        for (int k = 0; k < NX; k++) ld_x[k*BITS +: BITS] = BITS'(16'h1000 * (i + 1) + k);
        ld_y = BITS'(16'hA000 + i);
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    task automatic pulse_start(input int mep, input logic [BITS-1:0] lr);
        start  = 1'b1;
        max_ep = EW'(mep);
        lr_in  = lr;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic clear_counts();
        tr_cnt = 0;
        vl_cnt = 0;
    endtask

    // Returns at the negedge after done, i.e. once the DUT is back in IDLE.
    task automatic wait_done(input string name, input int budget, output int at);
        int n = 0;
        at = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s: got no done expected done within %0d cycles", name, budget);
        end
        at = cyc;
        @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_net_tr"}, net_tr, 0);
        chk({tag, "_net_vl"}, net_vl, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_net_lr"}, net_lr, 0);
        chk({tag, "_net_x"}, net_x, 0);
        chk({tag, "_net_y"}, net_y, 0);
        chk({tag, "_epoch"}, epoch, 0);
        chk({tag, "_errs"}, errs, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_ld_ready"}, ld_ready, 1);
    endtask

    initial begin : watchdog
        #2000000;
        errors++;
        $display("FAIL watchdog: got no end of test expected end within 200000 cycles");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

    initial begin : stim
        int at;
        int n;
        repeat (3) @(negedge clk);
        check_reset("rst0");
        rst_n = 1'b1;
        @(negedge clk);

        // Three samples, clean validation: one epoch.
        for (int i = 0; i < 3; i++) load_sample(i);
        errmask = '0;
        clear_counts();
        pulse_start(4, 16'h0002);
        wait_done("s1_done", 500, at);
        chk("s1_tr", tr_cnt, 3);
        chk("s1_vl", vl_cnt, 3);
        chk("s1_epoch", epoch, 1);
        chk("s1_errs", errs, 0);
        chk("s1_lr", net_lr, 16'h0002);
        chk("s1_timeout", timeout, 0);

        // Sample 1 always mispredicts: all four epochs run.
        errmask = 8'b0000_0010;
        clear_counts();
        pulse_start(4, 16'h0002);
        wait_done("s2_done", 1000, at);
        chk("s2_tr", tr_cnt, 12);
        chk("s2_vl", vl_cnt, 12);
        chk("s2_epoch", epoch, 4);
        chk("s2_errs", errs, 1);

        // Network never answers the first train pulse.
        errmask = '0;
        resp_on = 1'b0;
        m_tmo_exp = 1'b1;
        clear_counts();
        pulse_start(1, 16'h0100);
        wait_done("tmo_done", TMO + 50, at);
        chk("tmo_latency", at - tr_cyc, TMO + 1);
        chk("tmo_tr", tr_cnt, 1);
        chk("tmo_busy_after", busy, 0);
        chk("tmo_sticky", timeout, 1);
        m_tmo_exp = 1'b0;
        resp_on = 1'b1;

        // A fresh start clears the sticky timeout.
        clear_counts();
        pulse_start(1, 16'h0003);
        wait_done("s5_done", 500, at);
        chk("s5_timeout", timeout, 0);
        chk("s5_epoch", epoch, 1);
        chk("s5_lr", net_lr, 16'h0003);

        // Reset while waiting on a validate response.
        clear_counts();
        pulse_start(2, 16'h0004);
        n = 0;
        while (vl_cnt == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_reached_vl", vl_cnt, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset("rst_mid");
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start(3, 16'h0005);
        repeat (3) @(negedge clk);
        chk("start_empty_busy", busy, 0);

        // Load and start together from an empty buffer.
        clear_counts();
        ld_valid = 1'b1;
        for (int k = 0; k < NX; k++) ld_x[k*BITS +: BITS] = BITS'(16'h5500 + k);
        ld_y = 16'h5A5A;
        start = 1'b1;
        max_ep = 8'd1;
        lr_in = 16'h0006;
        @(negedge clk);
        ld_valid = 1'b0;
        start = 1'b0;
        wait_done("s7_done", 200, at);
        chk("s7_tr", tr_cnt, 1);
        chk("s7_vl", vl_cnt, 1);
        chk("s7_epoch", epoch, 1);

        // Clear wins over a same-cycle load, so a following start is ignored.
        clr = 1'b1;
        ld_valid = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        ld_valid = 1'b0;
        pulse_start(1, 16'h0007);
        repeat (3) @(negedge clk);
        chk("clr_load_busy", busy, 0);

        // Fill past capacity: the ninth sample is refused.
        for (int i = 0; i < DEPTH; i++) load_sample(i + 10);
        chk("full_ready", ld_ready, 0);
        load_sample(30);
        clear_counts();
        pulse_start(1, 16'h0008);
        wait_done("s8_done", 500, at);
        chk("s8_tr", tr_cnt, 8);
        chk("s8_vl", vl_cnt, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/train_sched.md
TRAIN_SCHED -- requirements
Module: train_sched

Interface
REQ-001 Parameters (name, default, meaning):
- NX, 6, feature inputs per sample
- BITS, 16, fixed-point word width, 8.8 format
- DEPTH, 8, sample buffer entries
- EW, 8, epoch counter width
- TMO, 2048, done-wait timeout in cycles
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on the rising edge
- rst_n, in, 1, reset; synchronous, active-low
- ld_valid, in, 1, sample write request
- ld_ready, out, 1, buffer accepts a sample
- ld_x, in, NX*BITS, sample features
- ld_y, in, BITS, sample target
- clr, in, 1, empty the buffer (honoured in IDLE only)
- start, in, 1, begin a training run
- max_ep, in, EW, epoch limit, sampled at start
- lr_in, in, BITS, learning rate, sampled at start
- net_tr, out, 1, one-cycle train pulse to the network
- net_vl, out, 1, one-cycle validate pulse to the network
- net_x, out, NX*BITS, features for the current sample
- net_y, out, BITS, target for the current sample
- net_lr, out, BITS, latched learning rate
- net_done, in, 1, network S_Train: operation complete
- net_err, in, 1, network S_Error: misprediction, valid with net_done
- busy, out, 1, run in progress
- done, out, 1, one-cycle run-complete pulse
- timeout, out, 1, sticky flag: last run aborted
- epoch, out, EW, completed epochs
- errs, out, $clog2(DEPTH+1), errors counted in the last validation pass

Function
REQ-003 FSM states: IDLE, TR_ISS, TR_WAIT, VL_ISS, VL_WAIT, EP_END, FIN.
REQ-004 Buffer loading:
- ld_ready = (state==IDLE) && count<DEPTH.
- A handshake writes entry[count] and increments count.
- When full, ld_ready=0 and count does not change.
REQ-005 clr in IDLE sets count=0; clr has priority over a same-cycle load. clr outside IDLE is ignored.
REQ-006 start in IDLE with count>0 and max_ep>0:
- latch lr_in and max_ep; idx=0, epoch=0, timeout=0
- next state TR_ISS
- otherwise start is ignored.
REQ-007 A load and start in the same cycle: the write is accepted and the run includes the new sample.
REQ-008 TR_ISS drives net_tr=1 for exactly one cycle with net_x/net_y=entry[idx], then goes to TR_WAIT.
- net_x/net_y stay stable until the matching net_done.
REQ-009 TR_WAIT on net_done:
- idx<count-1: idx++, go to TR_ISS
- else: idx=0, errs=0, go to VL_ISS
REQ-010 VL_ISS/VL_WAIT mirror REQ-008/009 using net_vl.
- errs increments on each net_done with net_err=1.
- After the last sample, go to EP_END.
REQ-011 EP_END increments epoch (saturating at 2^EW-1).
- errs==0 or epoch==max_ep: go to FIN.
- else: idx=0, go to TR_ISS.
REQ-012 FIN pulses done for one cycle, then returns to IDLE. epoch and errs hold until the next start.
REQ-013 Wait-state timer:
- resets on entry to each wait state
- counts cycles while in TR_WAIT/VL_WAIT
- at TMO with no net_done: timeout=1, go to FIN
REQ-014 net_done outside a wait state is ignored.
REQ-015 busy = (state != IDLE). net_tr and net_vl are never high together.

Reset
REQ-016 With rst_n=0 at a clock edge, the following apply at that edge:
- state=IDLE, count=0, idx=0
- epoch=0, errs=0, timeout=0
- net_tr=0, net_vl=0, done=0, busy=0
- net_lr=0, net_x=0, net_y=0
REQ-017 Reset mid-run aborts with no done pulse. Buffer contents are don't-care because count=0.

Structure
REQ-018 Package train_pkg holds:
- the state enum
- the BITS/NX defaults
- the fixed-point word typedef
REQ-019 Sample storage is one sub-module, sample_buf: DEPTH x (NX+1)*BITS, synchronous write, combinational read. The FSM stays in train_sched.

Verification
REQ-020 Directed scenarios:
- Load 3 samples, max_ep=4, lr_in=16'h0002, net_done 5 cycles after each pulse, net_err=0 -> 3 net_tr, then 3 net_vl, done with epoch=1, errs=0, net_lr=16'h0002.
- Same setup with net_err=1 on sample 1 in every validation pass -> 4 epochs run, done with epoch=4, errs=1.
- Load 9 samples with DEPTH=8 -> ld_ready drops after 8; the 9th is not accepted; count=8.
- net_done withheld after the first net_tr -> timeout=1 and done pulse exactly TMO cycles after TR_WAIT entry; busy=0 next cycle.
- rst_n=0 during VL_WAIT -> next cycle all outputs at reset values; start with count=0 ignored (busy stays 0).
- ld_valid and start in the same IDLE cycle with count=0 -> run proceeds with 1 sample; clr with ld_valid -> count=0.
